// File: rtl/ps2_keyboard_rx_pkg.sv
// rtl/ps2_keyboard_rx_pkg.sv - shared definitions for the PS/2 keyboard receiver
//
// Purpose: frame FSM state encoding, frame geometry and the odd-parity helper
// used by ps2_keyboard_rx and ps2_line_filter.
// Ports: none (package).

package ps2_keyboard_rx_pkg;

    typedef enum logic [1:0] {
        PS2_IDLE   = 2'd0,
        PS2_DATA   = 2'd1,
        PS2_PARITY = 2'd2,
        PS2_STOP   = 2'd3
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_line_filter.sv
// rtl/ps2_keyboard_rx_line_filter.sv - synchroniser, deglitch filter and falling-edge strobe for one PS/2 line
//
// Purpose: brings a raw asynchronous PS/2 pin into the Clock domain and only
// changes the filtered level after FILTER_LEN consecutive identical samples.
// Ports:
//   Clock    - system clock
//   Reset    - asynchronous, active-high; filtered level resets to 1 (bus idle)
//   iPin     - raw pin, asynchronous to Clock
//   oLevel   - filtered line level
//   oFallStb - one-cycle strobe on a filtered 1->0 transition

module ps2_line_filter
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iPin,
    output logic oLevel,
    output logic oFallStb
);

    localparam int CW = $clog2(FILTER_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          fall_stb_q, fall_stb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the current level;
    // the FILTER_LEN-th disagreeing sample flips the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        fall_stb_d = level_q & ~level_d;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            level_q    <= 1'b1;
            cnt_q      <= '0;
            fall_stb_q <= 1'b0;
        end else begin
            sync1_q    <= iPin;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            fall_stb_q <= fall_stb_d;
        end
    end

    assign oLevel   = level_q;
    assign oFallStb = fall_stb_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver with scancode FIFO
//
// Purpose: deframes 11-bit PS/2 frames sampled on filtered clock falling
// edges, checks start/odd-parity/stop, and queues good scancodes in a
// first-word fall-through FIFO popped by the core.
// Ports:
//   Clock, Reset - 50 MHz system clock, asynchronous active-high reset
//   iPS2Clk      - raw PS2_CLK pin
//   iPS2Data     - raw PS2_DATA pin
//   iPop         - one-cycle strobe consuming the head scancode
//   iClearErr    - clears the sticky error flags
//   oKey         - head scancode, 8'h00 when empty
//   oValid       - FIFO non-empty
//   oParityErr   - sticky parity failure
//   oFrameErr    - sticky bad start/stop bit or inter-edge timeout
//   oOverflow    - sticky good frame dropped on a full FIFO

module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2Clk,
    input  logic       iPS2Data,
    input  logic       iPop,
    input  logic       iClearErr,
    output logic [7:0] oKey,
    output logic       oValid,
    output logic       oParityErr,
    output logic       oFrameErr,
    output logic       oOverflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BIT = 3'(PS2_DATA_BITS - 1);

    logic clk_lvl, fall_stb, data_lvl, data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .Clock    (Clock),
        .Reset    (Reset),
        .iPin     (iPS2Clk),
        .oLevel   (clk_lvl),
        .oFallStb (fall_stb)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .Clock    (Clock),
        .Reset    (Reset),
        .iPin     (iPS2Data),
        .oLevel   (data_lvl),
        .oFallStb (data_fall)
    );

    // Only the clock strobe and the data level matter for deframing.
    logic unused_filter_outs;
    assign unused_filter_outs = clk_lvl ^ data_fall;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    logic [7:0]    push_data_q, push_data_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic frame_set, parity_set, ovf_set;
    logic fifo_full, fifo_pop, fifo_wr;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        frame_set   = 1'b0;
        parity_set  = 1'b0;

        if (fall_stb) begin
            tmo_d = '0;
            case (state_q)
                PS2_IDLE: begin
                    if (!data_lvl) begin
                        state_d  = PS2_DATA;
                        bitcnt_d = '0;
                    end else begin
                        frame_set = 1'b1;
                    end
                end
                PS2_DATA: begin
                    shreg_d  = {data_lvl, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = PS2_PARITY;
                    end
                end
                PS2_PARITY: begin
                    parity_d = data_lvl;
                    state_d  = PS2_STOP;
                end
                default: begin
                    if (!data_lvl) begin
                        frame_set = 1'b1;
                    end else if (ps2_parity_ok(shreg_q, parity_q)) begin
                        push_d      = 1'b1;
                        push_data_d = shreg_q;
                    end else begin
                        parity_set = 1'b1;
                    end
                    state_d = PS2_IDLE;
                end
            endcase
        end else if (state_q != PS2_IDLE) begin
            if (tmo_q == TMO_MAX) begin
                state_d   = PS2_IDLE;
                tmo_d     = '0;
                frame_set = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // FIFO: a same-cycle pop frees the slot the full-FIFO push needs.
    always_comb begin
        fifo_full = (count_q == CNT_FULL);
        fifo_pop  = iPop && (count_q != '0);
        fifo_wr   = push_q && (!fifo_full || fifo_pop);
        ovf_set   = push_q && fifo_full && !fifo_pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (fifo_wr && !fifo_pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (fifo_pop && !fifo_wr) begin
            count_d = count_q - (PW + 1)'(1);
        end

        // Set wins over a same-cycle clear.
        perr_d = parity_set | (perr_q & ~iClearErr);
        ferr_d = frame_set  | (ferr_q & ~iClearErr);
        ovf_d  = ovf_set    | (ovf_q  & ~iClearErr);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= PS2_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign oValid     = (count_q != '0);
    assign oKey       = oValid ? mem_q[rd_ptr_q] : 8'h00;
    assign oParityErr = perr_q;
    assign oFrameErr  = ferr_q;
    assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx

module tb_ps2_keyboard_rx;

    localparam int FLEN  = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 300;
    localparam int HALF  = 20;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iPS2Clk = 1'b1;
    logic       iPS2Data = 1'b1;
    logic       iPop = 1'b0;
    logic       iClearErr = 1'b0;
    logic [7:0] oKey;
    logic       oValid, oParityErr, oFrameErr, oOverflow;

    int n_checks = 0;
    int n_pass   = 0;

    ps2_keyboard_rx #(
        .FILTER_LEN     (FLEN),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iPS2Clk    (iPS2Clk),
        .iPS2Data   (iPS2Data),
        .iPop       (iPop),
        .iClearErr  (iClearErr),
        .oKey       (oKey),
        .oValid     (oValid),
        .oParityErr (oParityErr),
        .oFrameErr  (oFrameErr),
        .oOverflow  (oOverflow)
    );

    always #10 Clock = ~Clock;

    typedef struct {
        logic [7:0] d;
        bit         bad;
        bit         clr;
        int         pops;
        logic       v;
        logic [7:0] k;
        logic       pe;
        logic       fe;
        logic       ov;
    } vec_t;

    localparam int NV = 6;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic pop_n();
        iPop = 1'b1;
        @(negedge Clock);
        iPop = 1'b0;
        @(negedge Clock);
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, oKey, exp);
        pop_n();
    endtask

    task automatic clear_err();
        iClearErr = 1'b1;
        @(negedge Clock);
        iClearErr = 1'b0;
    endtask

    // Sends the first nbits of a frame; optional 3-cycle clock glitch in the
    // high phase of bit 4, optional pop strobe on the cycle the stop-bit
    // scancode reaches the FIFO write port (FLEN+3 cycles after the pin edge).
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit pop_at_push,
                              input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            @(negedge Clock);
            iPS2Data = fr[b];
            for (int c = 0; c < HALF; c++) begin
                iPS2Clk = !(glitch && b == 4 && c >= 8 && c < 11);
                @(negedge Clock);
            end
            iPS2Clk = 1'b0;
            for (int c = 0; c < HALF; c++) begin
                @(negedge Clock);
                iPop = pop_at_push && b == 10 && (c + 1 == FLEN + 3);
            end
            iPS2Clk = 1'b1;
        end
        iPop = 1'b0;
        cycles(HALF);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            d      bad  clr  pops v     k      pe    fe    ov
        tv[0] = '{8'h1C, 1'b0, 1'b0, 0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0};
        tv[1] = '{8'h1C, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tv[2] = '{8'hF0, 1'b0, 1'b1, 0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
        tv[3] = '{8'hA5, 1'b0, 1'b0, 0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
        tv[4] = '{8'h00, 1'b1, 1'b0, 2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tv[5] = '{8'hFF, 1'b0, 1'b1, 0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

        cycles(3);
        chk("reset valid", oValid, 8'h0);
        chk("reset key", oKey, 8'h00);
        chk("reset perr", oParityErr, 8'h0);
        chk("reset ferr", oFrameErr, 8'h0);
        chk("reset ovf", oOverflow, 8'h0);
        Reset = 1'b0;
        cycles(20);

        for (int i = 0; i < NV; i++) begin
            repeat (tv[i].pops) pop_n();
            if (tv[i].clr) clear_err();
            send_frame(tv[i].d, tv[i].bad, 1'b0, 1'b0, 11);
            chk($sformatf("vec%0d valid", i), oValid, tv[i].v);
            chk($sformatf("vec%0d key", i), oKey, tv[i].k);
            chk($sformatf("vec%0d perr", i), oParityErr, tv[i].pe);
            chk($sformatf("vec%0d ferr", i), oFrameErr, tv[i].fe);
            chk($sformatf("vec%0d ovf", i), oOverflow, tv[i].ov);
        end
        pop_n();
        chk("table drained", oValid, 8'h0);
        pop_n();
        chk("pop on empty ferr", oFrameErr, 8'h0);

        iPS2Clk = 1'b0;
        cycles(3);
        iPS2Clk = 1'b1;
        cycles(30);
        chk("idle glitch ferr", oFrameErr, 8'h0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 11);
        chk("glitch frame key", oKey, 8'hF0);
        chk("glitch frame valid", oValid, 8'h1);
        chk("glitch frame ferr", oFrameErr, 8'h0);
        chk("glitch frame perr", oParityErr, 8'h0);
        pop_n();

        clear_err();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 11);
        chk("overflow flag", oOverflow, 8'h1);
        chk("overflow valid", oValid, 8'h1);
        pop_chk("ovf pop0", 8'h01);
        pop_chk("ovf pop1", 8'h02);
        pop_chk("ovf pop2", 8'h03);
        pop_chk("ovf pop3", 8'h04);
        chk("ovf drained valid", oValid, 8'h0);
        chk("ovf drained key", oKey, 8'h00);

        clear_err();
        chk("ovf cleared", oOverflow, 8'h0);
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 11);
        send_frame(8'h05, 1'b0, 1'b1, 1'b0, 11);
        chk("push+pop ovf", oOverflow, 8'h0);
        pop_chk("pp pop0", 8'h02);
        pop_chk("pp pop1", 8'h03);
        pop_chk("pp pop2", 8'h04);
        pop_chk("pp pop3", 8'h05);
        chk("pp drained valid", oValid, 8'h0);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 5);
        iPS2Data = 1'b1;
        cycles(TMO - 100);
        chk("before timeout ferr", oFrameErr, 8'h0);
        cycles(150);
        chk("timeout ferr", oFrameErr, 8'h1);
        chk("timeout no push", oValid, 8'h0);
        clear_err();
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 11);
        chk("after timeout key", oKey, 8'h33);
        chk("after timeout ferr", oFrameErr, 8'h0);

        send_frame(8'h99, 1'b1, 1'b0, 1'b0, 11);
        chk("pre-reset perr", oParityErr, 8'h1);
        send_frame(8'h99, 1'b0, 1'b0, 1'b0, 4);
        Reset = 1'b1;
        cycles(3);
        chk("mid reset valid", oValid, 8'h0);
        chk("mid reset perr", oParityErr, 8'h0);
        Reset = 1'b0;
        iPS2Data = 1'b1;
        cycles(20);
        send_frame(8'h2A, 1'b0, 1'b0, 1'b0, 11);
        chk("post reset key", oKey, 8'h2A);
        chk("post reset valid", oValid, 8'h1);
        chk("post reset perr", oParityErr, 8'h0);
        chk("post reset ferr", oFrameErr, 8'h0);
        chk("post reset ovf", oOverflow, 8'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
PS/2 keyboard front end that feeds scancodes to the MiniAlu `TEC` instruction path. It replaces the ad-hoc filter/serial2parallel pair.
- Synchronises and deglitches PS2_CLK and PS2_DATA.
- Deframes 11-bit PS/2 frames and checks start, odd parity and stop bits.
- Buffers good scancodes in a small FIFO that the core pops, one byte per `TEC` execution.
- Runs entirely on the 50 MHz system Clock; no derived clocks.

Parameters:
FILTER_LEN, 8, consecutive identical samples needed to change a filtered line level (min 2)
FIFO_DEPTH, 4, scancode FIFO entries (power of two, min 2)
TIMEOUT_CYCLES, 100000, max Clock cycles between filtered PS2 clock falling edges inside a frame (2 ms at 50 MHz)

Ports:
Clock  input  1  system clock, 50 MHz
Reset  input  1  asynchronous, active-high reset
iPS2Clk  input  1  raw PS2_CLK pin, asynchronous to Clock
iPS2Data  input  1  raw PS2_DATA pin, asynchronous to Clock
iPop  input  1  consume head scancode (one-cycle strobe from core on TEC)
iClearErr  input  1  clears sticky error flags
oKey  output  8  FIFO head scancode (first-word fall-through); 8'h00 when empty
oValid  output  1  FIFO non-empty
oParityErr  output  1  sticky: a frame failed the odd-parity check
oFrameErr  output  1  sticky: bad start bit, bad stop bit, or timeout
oOverflow  output  1  sticky: good frame dropped because FIFO was full

Behaviour:
Clock and reset (already decided):
- Reset Reset, asynchronous, active-high; clock Clock.
- While Reset is high: oKey=0, oValid=0, all sticky flags 0, FSM=IDLE, FIFO empty, filtered lines=1, bit counter=0, timeout counter=0.

Input conditioning:
- Each pin passes through a 2-FF synchroniser, then a filter.
- Filter output goes to 1 after FILTER_LEN consecutive 1 samples and to 0 after FILTER_LEN consecutive 0 samples; otherwise it holds.
- A falling edge is a filtered-clock 1->0 transition, registered as a one-cycle strobe fall_stb.
- Pin edge to fall_stb latency is FILTER_LEN+2 cycles.
- Data is sampled from filtered data on the fall_stb cycle.

FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on fall_stb, if data=0 go to DATA with bitcnt=0. If data=1, set oFrameErr and stay in IDLE.
- DATA: on fall_stb, shift data into shreg[7] with LSB-first right shift, then bitcnt++. After the 8th bit go to PARITY.
- PARITY: on fall_stb, capture the parity bit and go to STOP.
- STOP:
  - On fall_stb with data=1 and ^{shreg,parity}==1, push shreg to the FIFO.
  - On fall_stb with data=1 and a parity mismatch, set oParityErr and do not push.
  - On fall_stb with data=0, set oFrameErr and do not push.
  - Always return to IDLE.

Timeout:
- The counter clears on every fall_stb and increments in any state other than IDLE.
- On reaching TIMEOUT_CYCLES-1 without fall_stb: go to IDLE, set oFrameErr, discard the partial byte.

FIFO:
- Push happens on the cycle after the stop-bit fall_stb. oValid/oKey update the following cycle.
- Pop occurs when iPop=1 and oValid=1 and advances the head next cycle. iPop while empty is ignored and raises no error.
- Push while full without a same-cycle pop: drop the byte and set oOverflow.
- Push while full with a same-cycle pop: both succeed and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. An extra count bit distinguishes full from empty.

Sticky flags:
- Cleared by iClearErr. If a set event and iClearErr occur in the same cycle, set wins.

Reset mid-frame:
- The partial frame is lost. After release the block waits in IDLE for the next start bit.
- A keyboard mid-frame at release causes at most one oFrameErr, via the timeout or a bad stop bit.

Decomposition:
Shared package (Definitions):
- FSM state encodings `PS2_IDLE/`PS2_DATA/`PS2_PARITY/`PS2_STOP (2 bits).
- `PS2_FRAME_BITS=11.

Sub-module ps2_line_filter:
- Contents: synchroniser, FILTER_LEN counter, level hold, fall strobe.
- Instantiated twice; only the clock instance's strobe is used.

FIFO:
- Inline in this module; too small to justify its own module.

Test Plan:
- Clean frame, 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1: start, LSB-first data, parity=0, stop), PS2 clock period 80 us, no pops -> oValid=1 and oKey=8'h1C one cycle after push; no error flags.
- Same frame with parity bit=1 -> oParityErr=1, oValid stays 0; then iClearErr pulse -> oParityErr=0.
- 3-cycle low glitch on iPS2Clk while IDLE and mid-DATA -> no fall_stb, no bit consumed; a following valid 0xF0 frame is received correctly.
- Five good frames 0x01..0x05 with no pops -> FIFO holds 0x01..0x04, oOverflow=1; four pops -> oKey sequence 01,02,03,04, then oValid=0, oKey=0.
- FIFO full while the core pulses iPop on the exact push cycle of 0x05 -> 0x05 accepted, oOverflow stays 0, final pop order 02,03,04,05.
- Stop iPS2Clk after 4 data bits for >TIMEOUT_CYCLES -> oFrameErr=1 and FSM back to IDLE. Separately, assert Reset mid-frame, release, send 0x2A -> oKey=8'h2A, all flags 0.
